pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/pipe_stage.sv | 61 ++++++
 rtl/pipe_reg_chain.sv | 131 +++++++++++++
 tb/tb_pipe_reg_chain.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipe_reg_chain register pipeline.
//   DEF_DATA_W / DEF_DEPTH / DEF_BUBBLE_COLLAPSE : default parameter values
//   stage_ctrl_t : per-stage control bundle computed by the chain, consumed
//                  by each pipe_stage instance
//   occ_width()  : width of the occupancy counter for a given depth
// ----------------------------------------------------------------------------
package pipe_pkg;

  localparam int unsigned DEF_DATA_W          = 32;
  localparam int unsigned DEF_DEPTH           = 4;
  localparam int unsigned DEF_BUBBLE_COLLAPSE = 1;

  // Control seen by one stage in one cycle.
  //   flush    : stage is selected for invalidation this cycle (wins over all)
  //   adv      : stage may take whatever its upstream neighbour presents
  //   up_valid : upstream neighbour really holds a payload to hand over
  typedef struct packed {
    logic flush;
    logic adv;
    logic up_valid;
  } stage_ctrl_t;

  // Enough bits to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage : pipe_pkg

// File: rtl/pipe_stage.sv
// ----------------------------------------------------------------------------
// pipe_stage
// One valid+data register slot of the pipeline.
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset, clears valid and data
//   i_ctrl       : flush / advance / upstream-valid control for this cycle
//   i_data       : payload offered by the upstream neighbour
//   o_valid_next : value the valid bit takes at the next edge (used by the
//                  chain for its registered occupancy count)
//   o_valid      : registered valid bit
//   o_data       : registered payload
// ----------------------------------------------------------------------------
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  stage_ctrl_t       i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid_next,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              w_load_data;

  // Flush beats everything; an advancing stage copies the upstream valid,
  // which turns it into a bubble when the upstream slot is empty.
  always_comb begin
    o_valid_next = r_valid;
    if (i_ctrl.flush) begin
      o_valid_next = 1'b0;
    end else if (i_ctrl.adv) begin
      o_valid_next = i_ctrl.up_valid;
    end
  end

  // Data only moves when a real payload lands here, so bubbles and flushed
  // moves leave the data register untouched.
  assign w_load_data = i_ctrl.adv && i_ctrl.up_valid && !i_ctrl.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      r_valid <= o_valid_next;
      if (w_load_data) begin
        r_data <= i_data;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule : pipe_stage

// File: rtl/pipe_reg_chain.sv
// ----------------------------------------------------------------------------
// pipe_reg_chain
// DEPTH-stage valid/ready register pipeline with freeze and per-stage flush.
//   Parameters
//     DATA_W          : payload width
//     DEPTH           : number of register stages (1..16)
//     BUBBLE_COLLAPSE : 1 = empty stages keep absorbing data while the output
//                       stalls, 0 = every stage shifts in lockstep
//   Ports
//     clk, rst               : clock, asynchronous active-low reset
//     in_valid/in_data       : upstream payload
//     in_ready               : chain accepts in_data this cycle
//     out_valid/out_data     : final-stage payload
//     out_ready              : downstream consumes out_data this cycle
//     freeze                 : hold every stage
//     flush, flush_mask      : invalidate the selected stages (bit 0 = input)
//     stage_valid            : registered valid bit of each stage
//     occupancy              : registered count of valid stages
// ----------------------------------------------------------------------------
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W          = DEF_DATA_W,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int BUBBLE_COLLAPSE = DEF_BUBBLE_COLLAPSE
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  output logic [DATA_W-1:0]                out_data,
  input  logic                             out_ready,
  input  logic                             freeze,
  input  logic                             flush,
  input  logic [DEPTH-1:0]                 flush_mask,
  output logic [DEPTH-1:0]                 stage_valid,
  output logic [occ_width(DEPTH)-1:0]      occupancy
);

  localparam int OCC_W = int'(occ_width(DEPTH));

  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_valid_next;
  logic [DEPTH-1:0]  w_ready;
  logic [DEPTH-1:0]  w_flush_sel;
  logic [DATA_W-1:0] w_data [DEPTH];
  logic [OCC_W-1:0]  w_occ_next;
  logic [OCC_W-1:0]  r_occupancy;

  assign w_flush_sel = {DEPTH{flush}} & flush_mask;

  // Ready ripples from the output back towards the input. Built in one
  // process, walking downwards, so each bit only reads an already-computed
  // downstream bit.
  always_comb begin
    w_ready            = '0;
    w_ready[DEPTH-1]   = !w_valid[DEPTH-1] || out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      if (BUBBLE_COLLAPSE != 0) begin
        w_ready[i] = !w_valid[i] || w_ready[i+1];
      end else begin
        w_ready[i] = w_ready[i+1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      stage_ctrl_t       w_ctrl;
      logic              w_up_valid;
      logic [DATA_W-1:0] w_up_data;

      if (gi == 0) begin : g_head
        assign w_up_valid = in_valid;
        assign w_up_data  = in_data;
      end else begin : g_body
        // A payload sitting in a stage that is being flushed this cycle is
        // already dead, so it must not slip into the next stage either.
        assign w_up_valid = w_valid[gi-1] && !w_flush_sel[gi-1];
        assign w_up_data  = w_data[gi-1];
      end

      assign w_ctrl = '{
        flush:    w_flush_sel[gi],
        adv:      w_ready[gi] && !freeze,
        up_valid: w_up_valid
      };

      pipe_stage #(
        .DATA_W (DATA_W)
      ) u_stage (
        .clk          (clk),
        .rst          (rst),
        .i_ctrl       (w_ctrl),
        .i_data       (w_up_data),
        .o_valid_next (w_valid_next[gi]),
        .o_valid      (w_valid[gi]),
        .o_data       (w_data[gi])
      );
    end
  endgenerate

  // Occupancy is registered from the next-state valid vector so it always
  // matches the popcount of stage_valid after every edge.
  always_comb begin
    w_occ_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_next = w_occ_next + OCC_W'(w_valid_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_occupancy <= '0;
    end else begin
      r_occupancy <= w_occ_next;
    end
  end

  // in_ready is forced low while reset is held; the stage registers are
  // empty then, which would otherwise advertise readiness.
  assign in_ready    = rst && w_ready[0] && !freeze && !w_flush_sel[0];
  assign out_valid   = w_valid[DEPTH-1] && !freeze && !w_flush_sel[DEPTH-1];
  assign out_data    = w_data[DEPTH-1];
  assign stage_valid = w_valid;
  assign occupancy   = r_occupancy;

endmodule : pipe_reg_chain

// File: tb/tb_pipe_reg_chain.sv
// ----------------------------------------------------------------------------
// tb_pipe_reg_chain
// Directed bench for pipe_reg_chain. Two instances share all inputs: one in
// collapse mode (dut_c) and one in lockstep mode (dut_l), DEPTH=4, DATA_W=32.
// ----------------------------------------------------------------------------
module tb_pipe_reg_chain;

  localparam int DW = 32;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          freeze;
  logic          flush;
  logic [DP-1:0] flush_mask;

  logic          c_in_ready, c_out_valid;
  logic [DW-1:0] c_out_data;
  logic [DP-1:0] c_stage_valid;
  logic [2:0]    c_occupancy;

  logic          l_in_ready, l_out_valid;
  logic [DW-1:0] l_out_data;
  logic [DP-1:0] l_stage_valid;
  logic [2:0]    l_occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_reg_chain #(.DATA_W(DW), .DEPTH(DP), .BUBBLE_COLLAPSE(1)) dut_c (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (c_in_ready),
    .out_valid   (c_out_valid),
    .out_data    (c_out_data),
    .out_ready   (out_ready),
    .freeze      (freeze),
    .flush       (flush),
    .flush_mask  (flush_mask),
    .stage_valid (c_stage_valid),
    .occupancy   (c_occupancy)
  );

  pipe_reg_chain #(.DATA_W(DW), .DEPTH(DP), .BUBBLE_COLLAPSE(0)) dut_l (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (l_in_ready),
    .out_valid   (l_out_valid),
    .out_data    (l_out_data),
    .out_ready   (out_ready),
    .freeze      (freeze),
    .flush       (flush),
    .flush_mask  (flush_mask),
    .stage_valid (l_stage_valid),
    .occupancy   (l_occupancy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    freeze     = 1'b0;
    flush      = 1'b0;
    flush_mask = '0;

    // Reset state, before any clock edge.
    #3;
    check_eq("rst_in_ready",    c_in_ready,    0);
    check_eq("rst_out_valid",   c_out_valid,   0);
    check_eq("rst_out_data",    c_out_data,    0);
    check_eq("rst_stage_valid", c_stage_valid, 0);
    check_eq("rst_occupancy",   c_occupancy,   0);
    check_eq("rst_l_in_ready",  l_in_ready,    0);
    step();
    step();
    rst = 1'b1;
    #1;
    check_eq("empty_in_ready",   c_in_ready,  1);
    check_eq("empty_l_in_ready", l_in_ready,  1);
    check_eq("empty_out_valid",  c_out_valid, 0);

    // Back-to-back push of three words, output always ready.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    #1;
    check_eq("b2b_in_ready", c_in_ready, 1);
    step();
    check_eq("b2b_sv1",  c_stage_valid, 4'b0001);
    check_eq("b2b_occ1", c_occupancy,   1);
    in_data = 32'h22;
    step();
    in_data = 32'h33;
    step();
    in_valid = 1'b0;
    check_eq("b2b_sv3",   c_stage_valid, 4'b0111);
    check_eq("b2b_occ3",  c_occupancy,   3);
    check_eq("b2b_nout3", c_out_valid,   0);
    step();
    check_eq("b2b_v4", c_out_valid, 1);
    check_eq("b2b_d4", c_out_data,  32'h11);
    step();
    check_eq("b2b_d5", c_out_data,  32'h22);
    step();
    check_eq("b2b_d6",   c_out_data,  32'h33);
    check_eq("b2b_occ6", c_occupancy, 1);
    step();
    check_eq("b2b_v7",   c_out_valid, 0);
    check_eq("b2b_occ7", c_occupancy, 0);

    // Output stalled: six offers, exactly four accepted.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA1 + k;
      #1;
      check_eq($sformatf("fill_in_ready_%0d", k),   c_in_ready, (k < 4) ? 1 : 0);
      check_eq($sformatf("fill_l_in_ready_%0d", k), l_in_ready, (k < 4) ? 1 : 0);
      step();
    end
    in_valid = 1'b0;
    #1;
    check_eq("full_occ",        c_occupancy,   4);
    check_eq("full_sv",         c_stage_valid, 4'b1111);
    check_eq("full_in_ready",   c_in_ready,    0);
    check_eq("full_l_in_ready", l_in_ready,    0);
    out_ready = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      check_eq($sformatf("drain_v_%0d", j), c_out_valid, 1);
      check_eq($sformatf("drain_d_%0d", j), c_out_data,  32'hA1 + j);
      step();
    end
    check_eq("drain_empty_v",   c_out_valid, 0);
    check_eq("drain_empty_occ", c_occupancy, 0);

    // Words in stages 1 and 3, output stalled: lockstep holds, collapse moves.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB1;
    step();
    in_valid = 1'b0;
    step();
    in_valid = 1'b1;
    in_data  = 32'hB2;
    step();
    in_valid = 1'b0;
    step();
    check_eq("gap_c_sv", c_stage_valid, 4'b1010);
    check_eq("gap_l_sv", l_stage_valid, 4'b1010);
    step();
    check_eq("stall_c_sv",       c_stage_valid, 4'b1100);
    check_eq("stall_l_sv",       l_stage_valid, 4'b1010);
    check_eq("stall_c_occ",      c_occupancy,   2);
    check_eq("stall_l_occ",      l_occupancy,   2);
    check_eq("stall_c_in_ready", c_in_ready,    1);
    check_eq("stall_l_in_ready", l_in_ready,    0);
    check_eq("stall_l_out_data", l_out_data,    32'hB1);
    out_ready = 1'b1;
    for (int j = 0; j < 5; j++) step();
    check_eq("gap_drain_c_occ", c_occupancy, 0);
    check_eq("gap_drain_l_occ", l_occupancy, 0);

    // Full chain, flush the two input-side stages.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hC1 + k;
      step();
    end
    in_valid = 1'b0;
    check_eq("pre_flush_sv", c_stage_valid, 4'b1111);
    flush      = 1'b1;
    flush_mask = 4'b0011;
    #1;
    check_eq("flush_in_ready",  c_in_ready,  0);
    check_eq("flush_out_valid", c_out_valid, 1);
    step();
    flush      = 1'b0;
    flush_mask = '0;
    #1;
    check_eq("flush_c_sv",  c_stage_valid, 4'b1100);
    check_eq("flush_l_sv",  l_stage_valid, 4'b1100);
    check_eq("flush_c_occ", c_occupancy,   2);
    out_ready = 1'b1;
    #1;
    check_eq("flush_out0_v", c_out_valid, 1);
    check_eq("flush_out0_d", c_out_data,  32'hC1);
    step();
    check_eq("flush_out1_d", c_out_data,  32'hC2);
    step();
    check_eq("flush_done_v", c_out_valid, 0);

    // Freeze for three cycles with both ports willing.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hD1;
    step();
    in_data = 32'hD2;
    step();
    in_valid = 1'b0;
    step();
    step();
    check_eq("pre_freeze_sv", c_stage_valid, 4'b1100);
    freeze    = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hD3;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      #1;
      check_eq($sformatf("frz_in_ready_%0d", j),  c_in_ready,    0);
      check_eq($sformatf("frz_out_valid_%0d", j), c_out_valid,   0);
      step();
      check_eq($sformatf("frz_sv_%0d", j),        c_stage_valid, 4'b1100);
      check_eq($sformatf("frz_occ_%0d", j),       c_occupancy,   2);
      check_eq($sformatf("frz_data_%0d", j),      c_out_data,    32'hD1);
    end
    freeze   = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("thaw_v0", c_out_valid, 1);
    check_eq("thaw_d0", c_out_data,  32'hD1);
    step();
    check_eq("thaw_d1", c_out_data,  32'hD2);
    step();
    check_eq("thaw_empty_v",   c_out_valid, 0);
    check_eq("thaw_empty_occ", c_occupancy, 0);

    // Asynchronous reset between edges while words are in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hE1;
    step();
    in_data = 32'hE2;
    step();
    in_valid = 1'b0;
    check_eq("pre_arst_occ", c_occupancy, 2);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_sv",       c_stage_valid, 0);
    check_eq("arst_occ",      c_occupancy,   0);
    check_eq("arst_in_ready", c_in_ready,    0);
    check_eq("arst_out_data", c_out_data,    0);
    step();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hF1;
    #1;
    check_eq("post_rst_in_ready", c_in_ready, 1);
    step();
    in_valid = 1'b0;
    check_eq("lat_v1", c_out_valid, 0);
    step();
    check_eq("lat_v2", c_out_valid, 0);
    step();
    check_eq("lat_v3", c_out_valid, 0);
    step();
    check_eq("lat_v4", c_out_valid, 1);
    check_eq("lat_d4", c_out_data,  32'hF1);
    step();
    check_eq("lat_v5",   c_out_valid, 0);
    check_eq("lat_occ5", c_occupancy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipe_reg_chain
